// File: rtl/shift_add_multiplier_8_pkg.sv
// rtl/shift_add_multiplier_8_pkg.sv - shared widths and datapath helper for the shift-add multiplier
package shift_add_multiplier_8_pkg;

  localparam int MULT_WIDTH = 8;
  localparam int CNT_WIDTH  = 3;

  // One right shift of {c, a, q}; the carry drops into the top of the accumulator.
  function automatic logic [2*MULT_WIDTH-1:0] shift_pair(
    input logic                  c,
    input logic [MULT_WIDTH-1:0] a,
    input logic [MULT_WIDTH-1:0] q
  );
    return {c, a, q[MULT_WIDTH-1:1]};
  endfunction

endpackage

// File: rtl/shift_add_multiplier_8_if.sv
// rtl/shift_add_multiplier_8_if.sv - start/busy/done handshake and operand/result bundle
interface shift_add_multiplier_8_if #(
  parameter int WIDTH = 8
);

  logic               start;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  modport master (
    output start, in1, in2,
    input  product, busy, done
  );

  modport slave (
    input  start, in1, in2,
    output product, busy, done
  );

endinterface

// File: rtl/carry_select_adder_8.sv
// rtl/carry_select_adder_8.sv - 8-bit carry-select adder, upper nibble precomputed for both carries
module carry_select_adder_8 (
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  assign lo  = {1'b0, in1[3:0]} + {1'b0, in2[3:0]} + {4'b0, cin};
  assign hi0 = {1'b0, in1[7:4]} + {1'b0, in2[7:4]};
  assign hi1 = {1'b0, in1[7:4]} + {1'b0, in2[7:4]} + 5'd1;

  assign sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
  assign cout = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/shift_add_multiplier_8.sv
// rtl/shift_add_multiplier_8.sv - sequential 8x8 unsigned shift-and-add multiplier
// One add-and-shift per RUN cycle through carry_select_adder_8; result lands on the RUN->DONE edge.
module shift_add_multiplier_8
  import shift_add_multiplier_8_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = CNT_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  shift_add_multiplier_8_if.slave bus
);

  if (WIDTH != 8) begin : g_width_check
    $error("shift_add_multiplier_8: WIDTH must be 8 to match carry_select_adder_8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               c_add;
  logic [WIDTH-1:0]   a_add;
  logic [2*WIDTH-1:0] aq_next;

  carry_select_adder_8 u_adder (
    .in1  (a),
    .in2  (m),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // cout is the ninth bit of the partial sum; it becomes the new accumulator MSB after the shift.
  always_comb begin
    c_add   = 1'b0;
    a_add   = a;
    if (q[0]) begin
      c_add = cout;
      a_add = sum;
    end
    aq_next = shift_pair(c_add, a_add, q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      m           <= '0;
      a           <= '0;
      q           <= '0;
      count       <= '0;
      bus.product <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            m        <= bus.in1;
            q        <= bus.in2;
            a        <= '0;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a     <= aq_next[2*WIDTH-1:WIDTH];
          q     <= aq_next[WIDTH-1:0];
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            bus.product <= aq_next;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
